// File: rtl/if_fetch_controller.sv
// IF-stage fetch controller: decodes PC/nPC/IF-ID enables, next-PC select and
// delay-slot annulment from pipeline status, tolerating a multi-cycle imem.
module if_fetch_controller #(
    parameter int RESET_HOLD  = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   R,
    input  logic                   imem_ready,
    input  logic                   hazard_stall,
    input  logic                   br_valid,
    input  logic                   br_taken,
    input  logic                   br_always,
    input  logic                   br_annul,
    input  logic                   jmpl_valid,
    output logic                   pc_le,
    output logic                   npc_le,
    output logic                   ifid_le,
    output logic                   ifid_clear,
    output logic [1:0]             mux_sel,
    output logic                   pipe_hold,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // state | meaning
    // INIT  | post-reset hold, IF/ID flushed, nothing fetched
    // FETCH | normal fetch, imem answered last cycle or first fetch
    // WAIT  | imem busy, pipeline frozen until imem_ready
    localparam logic [1:0] ST_INIT  = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;

    localparam logic [1:0] SEL_NPC = 2'b00;
    localparam logic [1:0] SEL_TA  = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    localparam logic [3:0]             HOLD_INIT = 4'(RESET_HOLD - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic [1:0]             state_q, state_d;
    logic [3:0]             hold_q, hold_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic [1:0] redirect_sel;
    logic       annul;

    // An older JMPL in EX wins over a branch sitting in its delay slot.
    always_comb begin
        redirect_sel = SEL_NPC;
        if (jmpl_valid) begin
            redirect_sel = SEL_ALU;
        end else if (br_valid && br_taken) begin
            redirect_sel = SEL_TA;
        end
    end

    assign annul = br_valid & br_annul & ~jmpl_valid & (~br_taken | br_always);

    always_comb begin
        pc_le      = 1'b0;
        npc_le     = 1'b0;
        ifid_le    = 1'b0;
        ifid_clear = 1'b0;
        mux_sel    = SEL_NPC;
        pipe_hold  = 1'b0;
        state_d    = state_q;
        hold_d     = hold_q;

        case (state_q)
            ST_FETCH, ST_WAIT: begin
                mux_sel = redirect_sel;
                if (!imem_ready) begin
                    pipe_hold = 1'b1;
                    state_d   = ST_WAIT;
                end else begin
                    state_d = ST_FETCH;
                    if (!hazard_stall) begin
                        pc_le      = 1'b1;
                        npc_le     = 1'b1;
                        ifid_le    = 1'b1;
                        ifid_clear = annul;
                    end else if (jmpl_valid) begin
                        // Take the JMPL redirect; the delay slot stays in IF/ID.
                        pc_le  = 1'b1;
                        npc_le = 1'b1;
                    end
                end
            end
            default: begin
                ifid_clear = 1'b1;
                pipe_hold  = 1'b1;
                if (hold_q == 4'd0) begin
                    state_d = ST_FETCH;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if ((state_q != ST_INIT) && !pc_le && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q <= ST_INIT;
            hold_q  <= HOLD_INIT;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stall_q <= stall_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_if_fetch_controller.sv
// Randomized and directed bench for if_fetch_controller against a rule-level
// reference model of the fetch behaviour.
module tb_if_fetch_controller;

    localparam int HOLD = 2;
    localparam int SW   = 6;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          R   = 1'b1;
    logic          imem_ready = 1'b0, hazard_stall = 1'b0;
    logic          br_valid = 1'b0, br_taken = 1'b0, br_always = 1'b0, br_annul = 1'b0;
    logic          jmpl_valid = 1'b0;
    logic          pc_le, npc_le, ifid_le, ifid_clear, pipe_hold;
    logic [1:0]    mux_sel, state;
    logic [SW-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0=INIT 1=FETCH 2=WAIT_MEM, cycles left in INIT, stall count.
    int m_mode, m_left, m_stall;

    if_fetch_controller #(.RESET_HOLD(HOLD), .STALL_CNT_W(SW)) dut (
        .clk(clk), .R(R), .imem_ready(imem_ready), .hazard_stall(hazard_stall),
        .br_valid(br_valid), .br_taken(br_taken), .br_always(br_always),
        .br_annul(br_annul), .jmpl_valid(jmpl_valid), .pc_le(pc_le),
        .npc_le(npc_le), .ifid_le(ifid_le), .ifid_clear(ifid_clear),
        .mux_sel(mux_sel), .pipe_hold(pipe_hold), .state(state),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_left  = HOLD;
        m_stall = 0;
    endtask

    task automatic set_in(input bit rdy, input bit hz, input bit bv, input bit bt,
                          input bit ba, input bit an, input bit jv);
        imem_ready = rdy; hazard_stall = hz; br_valid = bv; br_taken = bt;
        br_always = ba; br_annul = an; jmpl_valid = jv;
    endtask

    // Checks every output against the model for the current inputs, then
    // advances the model across the coming rising edge.
    task automatic cycle();
        int e_pc, e_ifid, e_clr, e_mux, e_hold;
        bit ann;
        #1;
        e_pc = 0; e_ifid = 0; e_clr = 0; e_mux = 0; e_hold = 0;
        if (m_mode == 0) begin
            e_clr = 1; e_hold = 1;
        end else begin
            e_mux = jmpl_valid ? 2 : ((br_valid && br_taken) ? 1 : 0);
            ann = br_valid && br_annul && !jmpl_valid && (!br_taken || br_always);
            if (!imem_ready) e_hold = 1;
            else if (!hazard_stall) begin e_pc = 1; e_ifid = 1; e_clr = int'(ann); end
            else if (jmpl_valid) e_pc = 1;
        end
        chk("state", state, m_mode);
        chk("pc_le", pc_le, e_pc);
        chk("npc_le", npc_le, e_pc);
        chk("ifid_le", ifid_le, e_ifid);
        chk("ifid_clear", ifid_clear, e_clr);
        chk("mux_sel", mux_sel, e_mux);
        chk("pipe_hold", pipe_hold, e_hold);
        chk("stall_cnt", stall_cnt, m_stall);
        if (m_mode == 0) begin
            m_left--;
            if (m_left == 0) m_mode = 1;
        end else begin
            if (e_pc == 0 && m_stall < SMAX) m_stall++;
            m_mode = imem_ready ? 1 : 2;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_clear", ifid_clear, 1);
        @(negedge clk);
        R = 1'b0;
        model_reset();

        // Reset release with imem ready: two INIT cycles then plain fetch.
        set_in(1, 0, 0, 0, 0, 0, 0);
        repeat (HOLD) cycle();
        #1;
        chk("post_init_state", state, 1);
        chk("post_init_pc_le", pc_le, 1);
        cycle();

        // Branch cases.
        set_in(1, 0, 1, 1, 0, 0, 0); cycle();
        set_in(1, 0, 1, 1, 1, 1, 0); cycle();
        set_in(1, 0, 1, 0, 0, 1, 0); cycle();
        set_in(1, 0, 1, 0, 0, 0, 0); cycle();

        // Memory wait of three cycles.
        set_in(0, 0, 1, 1, 0, 0, 0);
        repeat (3) cycle();
        #1;
        chk("wait_state", state, 2);
        chk("wait_stall", stall_cnt, 3);
        set_in(1, 0, 1, 1, 0, 0, 0); cycle();
        set_in(1, 0, 0, 0, 0, 0, 0); cycle();

        // Hazard alone, then hazard with JMPL overriding a branch.
        set_in(1, 1, 0, 0, 0, 0, 0); cycle();
        set_in(1, 1, 1, 1, 1, 1, 1); cycle();
        #1;
        chk("jmpl_state", state, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(3) != 0, $urandom_range(4) == 0, $urandom_range(1) == 1,
                   $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(1) == 1,
                   $urandom_range(5) == 0);
            cycle();
        end

        // Saturation under continuous stall.
        set_in(1, 1, 0, 0, 0, 0, 0);
        repeat (SMAX + 8) cycle();
        #1;
        chk("sat_stall", stall_cnt, SMAX);

        // Asynchronous reset in the middle of a memory wait.
        set_in(0, 0, 1, 1, 0, 0, 1);
        cycle();
        #2;
        R = 1'b1;
        #1;
        chk("async_state", state, 0);
        chk("async_stall", stall_cnt, 0);
        chk("async_clear", ifid_clear, 1);
        model_reset();
        @(negedge clk);
        R = 1'b0;
        model_reset();
        for (int i = 0; i < 60; i++) begin
            set_in($urandom_range(2) != 0, $urandom_range(3) == 0, $urandom_range(1) == 1,
                   $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(1) == 1,
                   $urandom_range(3) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
